sine_seq: RTL

Sequencer that drives the unrolled combinational `sine` datapath. It generates UNR phase words per cycle from a phase accumulator (phase0, tuning word ftw) and presents them to `sine`. It captures the UNR sine results into a registered output stage with a valid/ready handshake. It runs for a programmed number of blocks, or continuously until stopped, and sits between the control registers and the downstream sample consumer.

---
 rtl/sine_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sine_seq.sv
// sine_seq
// ---------------------------------------------------------------------------
// Sequencer for the unrolled combinational sine datapath. A phase accumulator
// produces UNR consecutive phase words per cycle (acc, acc+ftw, acc+2*ftw,...)
// which go out to the external sine block; the UNR results that come back are
// captured into a registered output stage guarded by a valid/ready handshake.
// A run is either a programmed number of blocks or continuous until stopped.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      begin a run (only looked at while idle)
//   stop       abort a run (only looked at while running)
//   phase0     initial phase, latched at start
//   ftw        per-sample phase increment, latched at start
//   nblk       number of UNR-sample blocks, 0 = continuous, latched at start
//   phase_out  UNR phase words to the sine datapath
//   sine_in    UNR sine results, combinational from phase_out
//   out_data   registered block of UNR sine results
//   out_valid  out_data holds a block not yet consumed
//   out_ready  consumer takes out_data when out_valid && out_ready
//   busy       high while running or flushing
//   done       one-cycle pulse when a run completes or is aborted
// ---------------------------------------------------------------------------
module sine_seq #(
    parameter int DWIDTH = 14,
    parameter int UNR    = 4,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic [DWIDTH-1:0] phase0,
    input  logic [DWIDTH-1:0] ftw,
    input  logic [CWIDTH-1:0] nblk,
    output logic [DWIDTH-1:0] phase_out [UNR],
    input  logic [DWIDTH:0]   sine_in   [UNR],
    output logic [DWIDTH:0]   out_data  [UNR],
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DWIDTH-1:0] acc;
    logic [DWIDTH-1:0] ftw_r;
    logic [CWIDTH-1:0] nblk_r;
    logic [CWIDTH-1:0] cnt;

    logic              start_ok;
    logic              load;
    logic              last_blk;
    logic              flush_exit;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A run leaves RUN either on an abort or on the load of
    // the final block; FLUSH waits until the last captured block has gone out.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop || last_blk) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_exit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode. The phase words are a pure function of the
    // registers so the sine datapath always sees a stable, defined input.
    // A load only happens when the output register is free or being drained
    // in the same cycle, which gives one block per cycle under full ready.
    always_comb begin
        busy       = (state != IDLE);
        start_ok   = (state == IDLE) && start && !stop;
        load       = (state == RUN) && !stop && (!out_valid || out_ready);
        last_blk   = load && (nblk_r != '0) && ((cnt + CWIDTH'(1)) == nblk_r);
        flush_exit = (state == FLUSH) && (!out_valid || out_ready);
        for (int k = 0; k < UNR; k++) begin
            phase_out[k] = acc + ftw_r * DWIDTH'(k);
        end
    end

    // Datapath registers. The accumulator advances by UNR samples per load;
    // the output stage keeps its block until the consumer takes it. done is
    // registered so it rises together with the return to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc       <= '0;
            ftw_r     <= '0;
            nblk_r    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < UNR; k++) begin
                out_data[k] <= '0;
            end
        end else begin
            done <= flush_exit;
            if (start_ok) begin
                acc    <= phase0;
                ftw_r  <= ftw;
                nblk_r <= nblk;
                cnt    <= '0;
            end else if (load) begin
                acc <= acc + ftw_r * DWIDTH'(UNR);
                cnt <= cnt + CWIDTH'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                for (int k = 0; k < UNR; k++) begin
                    out_data[k] <= sine_in[k];
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
